// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM encoding, the NOP word
// returned while stalled, and the address-split width helpers.
package icache_pkg;

    localparam int ADDR_W = 30;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

    function automatic int calc_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int calc_idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int calc_tag_w(input int line_words, input int num_lines);
        return ADDR_W - calc_off_w(line_words) - calc_idx_w(num_lines);
    endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Core fetch port plus memory refill port of the instruction cache.
// The cache connects through the slave modport, its environment through master.
interface instr_cache_if;
    import icache_pkg::*;

    logic [ADDR_W-1:0] core_addr_i;
    logic [31:0]       core_data_o;
    logic              core_blocking_n_o;
    logic              flush_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [31:0]       mem_data_i;

    modport slave (
        input  core_addr_i, flush_i, mem_ack_i, mem_data_i,
        output core_data_o, core_blocking_n_o, mem_req_o, mem_addr_o
    );

    modport master (
        output core_addr_i, flush_i, mem_ack_i, mem_data_i,
        input  core_data_o, core_blocking_n_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/icache_data_ram.sv
// Instruction cache data array: asynchronous read, synchronous single write.
module icache_data_ram
    import icache_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    parameter  int NUM_LINES  = 64,
    localparam int OFF_W      = calc_off_w(LINE_WORDS),
    localparam int IDX_W      = calc_idx_w(NUM_LINES)
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [OFF_W-1:0] i_rd_off,
    output logic [31:0]      o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [OFF_W-1:0] i_wr_word,
    input  logic [31:0]      i_wr_data
);

    logic [31:0] r_mem [NUM_LINES*LINE_WORDS];

    // refill write, one word per acked memory beat
    always_ff @(posedge clk_i) begin
        if (i_wr_en) r_mem[{i_wr_idx, i_wr_word}] <= i_wr_data;
    end

    assign o_rd_data = r_mem[{i_rd_idx, i_rd_off}];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache. Hits are combinational; a miss
// stalls the core while the whole line is fetched word by word, in order.
module instr_cache
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    instr_cache_if.slave bus
);

    localparam int OFF_W = calc_off_w(LINE_WORDS);
    localparam int IDX_W = calc_idx_w(NUM_LINES);
    localparam int TAG_W = calc_tag_w(LINE_WORDS, NUM_LINES);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    state_t                    r_state, w_next;
    logic [NUM_LINES-1:0]      r_valid;
    logic [TAG_W-1:0]          r_tag [NUM_LINES];
    logic [ADDR_W-OFF_W-1:0]   r_refill_line;   // {tag, index} of the line being filled
    logic [OFF_W-1:0]          r_cnt;
    logic                      r_flush_pending;

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic [31:0]      w_rd_data;
    logic             w_hit, w_start, w_fill_ack, w_fill_done;

    assign w_off      = bus.core_addr_i[OFF_W-1:0];
    assign w_idx      = bus.core_addr_i[OFF_W +: IDX_W];
    assign w_tag      = bus.core_addr_i[ADDR_W-1 -: TAG_W];
    assign w_fill_idx = r_refill_line[IDX_W-1:0];
    assign w_fill_tag = r_refill_line[IDX_W +: TAG_W];

    assign w_hit       = (r_state == ST_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // a flush in the same cycle as a miss wins; the miss retries next cycle
    assign w_start     = (r_state == ST_IDLE) && !w_hit && !bus.flush_i && !r_flush_pending;
    assign w_fill_ack  = (r_state == ST_REFILL) && bus.mem_ack_i;
    assign w_fill_done = w_fill_ack && (r_cnt == LAST_WORD);

    assign bus.core_blocking_n_o = w_hit;
    assign bus.core_data_o       = w_hit ? w_rd_data : NOP_INSTR;

    icache_data_ram #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_data_ram (
        .clk_i     (clk_i),
        .i_rd_idx  (w_idx),
        .i_rd_off  (w_off),
        .o_rd_data (w_rd_data),
        .i_wr_en   (w_fill_ack),
        .i_wr_idx  (w_fill_idx),
        .i_wr_word (r_cnt),
        .i_wr_data (bus.mem_data_i)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // FSM next state: start on a miss, return once the last word is acked
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start)     w_next = ST_REFILL;
            ST_REFILL: if (w_fill_done) w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: request held with a stable address until each ack
    always_comb begin
        bus.mem_req_o  = 1'b0;
        bus.mem_addr_o = '0;
        if (r_state == ST_REFILL) begin
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = {r_refill_line, r_cnt};
        end
    end

    // refill bookkeeping, valid bits and deferred flush
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid         <= '0;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
            r_refill_line   <= '0;
        end else begin
            if (w_start) begin
                r_refill_line <= bus.core_addr_i[ADDR_W-1:OFF_W];
                r_cnt         <= '0;
            end
            if (w_fill_ack) r_cnt <= r_cnt + OFF_W'(1);
            if (r_state == ST_IDLE) begin
                if (bus.flush_i) r_valid <= '0;
            end else if (w_fill_done) begin
                // a flush seen during the refill also kills the line just filled
                if (r_flush_pending || bus.flush_i) r_valid <= '0;
                else                                r_valid[w_fill_idx] <= 1'b1;
                r_flush_pending <= 1'b0;
            end else if (bus.flush_i) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    // tag written together with the final word of the line
    always_ff @(posedge clk_i) begin
        if (w_fill_done && !rst_i) r_tag[w_fill_idx] <= w_fill_tag;
    end

endmodule
